// File: rtl/dm_stb_pkg.sv
// -----------------------------------------------------------------------------
// dm_stb_pkg
// Shared types and sizes for the data-memory store buffer.
//   STB_DEPTH / STB_AW / STB_DW : default geometry (entries, address, data bits)
//   STB_BE_W                    : byte lanes per word (DW/8)
//   STB_PTR_W                   : ring pointer width (log2 DEPTH)
//   stb_entry_t                 : one queued store {addr, data, be, pc}
//   stb_state_e                 : fence FSM states
// -----------------------------------------------------------------------------
package dm_stb_pkg;

   localparam int STB_DEPTH = 4;
   localparam int STB_AW    = 32;
   localparam int STB_DW    = 32;
   localparam int STB_BE_W  = STB_DW / 8;
   localparam int STB_PTR_W = $clog2(STB_DEPTH);

   typedef struct packed {
      logic [STB_AW-1:0]   addr;
      logic [STB_DW-1:0]   data;
      logic [STB_BE_W-1:0] be;
      logic [STB_AW-1:0]   pc;
   } stb_entry_t;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FENCE = 2'd1,
      S_DONE  = 2'd2
   } stb_state_e;

endpackage

// File: rtl/stb_fwd_match.sv
// -----------------------------------------------------------------------------
// stb_fwd_match
// Load-hit forwarding network for dm_store_buffer, present only when the
// STB_FWD_EN macro is defined (the module is not built otherwise).
// Compares the load word index against every valid entry and, per byte lane,
// picks the data of the youngest matching entry whose byte enable is set.
// Ports:
//   i_valid     per-entry valid bits
//   i_rd_ptr    ring index of the oldest entry (age reference)
//   i_ent_word  per-entry word index (addr[AW-1:2])
//   i_ent_data  per-entry lane-aligned data
//   i_ent_be    per-entry byte enables
//   i_ld_word   word index of the load in MEM
//   o_fwd_be    lanes supplied by the buffer
//   o_fwd_data  forwarded bytes, uncovered lanes are 0
// -----------------------------------------------------------------------------
`ifdef STB_FWD_EN
module stb_fwd_match
   import dm_stb_pkg::*;
#(
   parameter int DEPTH = STB_DEPTH,
   parameter int AW    = STB_AW,
   parameter int DW    = STB_DW
)
(
   input  logic [DEPTH-1:0]         i_valid,
   input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
   input  logic [AW-3:0]            i_ent_word [DEPTH],
   input  logic [DW-1:0]            i_ent_data [DEPTH],
   input  logic [DW/8-1:0]          i_ent_be   [DEPTH],
   input  logic [AW-3:0]            i_ld_word,
   output logic [DW/8-1:0]          o_fwd_be,
   output logic [DW/8-1:0][7:0]     o_fwd_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int BE_W  = DW / 8;

   // Walk entries oldest to youngest starting at the head; a later match
   // overwrites an earlier one lane by lane, so the youngest writer wins.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      o_fwd_be   = '0;
      o_fwd_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_rd_ptr + PTR_W'(k);
         if (i_valid[w_idx] && (i_ent_word[w_idx] == i_ld_word)) begin
            for (int l = 0; l < BE_W; l++) begin
               if (i_ent_be[w_idx][l]) begin
                  o_fwd_be[l]   = 1'b1;
                  o_fwd_data[l] = i_ent_data[w_idx][8*l +: 8];
               end
            end
         end
      end
   end

endmodule
`endif

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
// Posted-store FIFO between the MIPS MEM stage and data memory. Stores are
// queued in a ring buffer and drained to dm one per cycle; a fence handshake
// lets the core wait until every queued store has reached dm; loads that hit
// pending stores are either forwarded or stalled.
// Optional feature macro: STB_FWD_EN (defined: byte forwarding through
// stb_fwd_match, ld_conflict=0; undefined: ld_conflict stalls on any word hit).
// Ports:
//   CLK, Reset                 clock, synchronous active-high reset
//   st_valid/st_ready          store request handshake
//   st_addr/st_data/st_be/st_pc store payload (lane-aligned data)
//   dm_wr, dm_addr/wd/be/pc    head entry write towards dm
//   dm_busy                    dm stalls the head this cycle
//   ld_addr                    load address in MEM
//   ld_conflict, ld_fwd_be/data load-hit result
//   fence_req/fence_done       drain-to-empty request and completion pulse
//   empty                      no valid entries
//   dbg_state                  fence FSM state, for observation only
// -----------------------------------------------------------------------------
module dm_store_buffer
   import dm_stb_pkg::*;
#(
   parameter int DEPTH = STB_DEPTH,
   parameter int AW    = STB_AW,
   parameter int DW    = STB_DW
)
(
   input  logic            CLK,
   input  logic            Reset,
   input  logic            st_valid,
   output logic            st_ready,
   input  logic [AW-1:0]   st_addr,
   input  logic [DW-1:0]   st_data,
   input  logic [DW/8-1:0] st_be,
   input  logic [AW-1:0]   st_pc,
   output logic            dm_wr,
   output logic [AW-1:0]   dm_addr,
   output logic [DW-1:0]   dm_wd,
   output logic [DW/8-1:0] dm_be,
   output logic [AW-1:0]   dm_pc,
   input  logic            dm_busy,
   input  logic [AW-1:0]   ld_addr,
   output logic            ld_conflict,
   output logic [DW/8-1:0] ld_fwd_be,
   output logic [DW-1:0]   ld_fwd_data,
   input  logic            fence_req,
   output logic            fence_done,
   output logic            empty,
   output stb_state_e      dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BE_W  = DW / 8;

   // Entry payload layout comes from dm_stb_pkg; AW/DW must match it.
   stb_entry_t       r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   stb_state_e       r_state;

   stb_state_e       w_state_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   stb_entry_t       w_new;
   stb_entry_t       w_head;

   // Handshakes: a store transfers at a rising edge where st_valid && st_ready
   // are both 1; a dm write transfers at an edge where dm_wr=1 (dm_busy=1
   // holds the head and forces dm_wr=0). st_ready and dm_wr depend only on
   // registered state plus dm_busy, never on st_valid.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_push  = st_valid && st_ready;
   assign w_pop   = dm_wr;
   assign dm_wr   = !w_empty && !dm_busy;
   assign empty   = w_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // ---------------- fence FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (Reset) r_state <= S_RUN;
      else       r_state <= w_state_nxt;
   end

   // ---------------- fence FSM: next state ----------------
   // The fence completes on the edge that leaves the buffer empty, which also
   // covers a store pushed alongside fence_req (it must drain first).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (fence_req) w_state_nxt = (w_count_nxt == '0) ? S_DONE : S_FENCE;
         end
         S_FENCE: begin
            if (w_count_nxt == '0) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_RUN;
         default: w_state_nxt = S_RUN;
      endcase
   end

   // ---------------- fence FSM: outputs ----------------
   // Using the registered count means a pop while full cannot raise st_ready.
   always_comb begin
      st_ready   = 1'b0;
      fence_done = 1'b0;
      case (r_state)
         S_RUN:   st_ready   = !w_full;
         S_DONE:  fence_done = 1'b1;
         default: begin
            st_ready   = 1'b0;
            fence_done = 1'b0;
         end
      endcase
   end

   assign dbg_state = r_state;

   // ---------------- ring buffer control ----------------
   // Push never targets the head slot while it is valid (st_ready=0 when
   // full), so set and clear of r_valid never collide on one bit.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   assign w_new = '{addr: st_addr, data: st_data, be: st_be, pc: st_pc};

   // Payload storage needs no reset: r_valid/r_count qualify every read.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= w_new;
   end

   assign w_head  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign dm_addr = w_head.addr;
   assign dm_wd   = w_head.data;
   assign dm_be   = w_head.be;
   assign dm_pc   = w_head.pc;

   // ---------------- load hit ----------------
   // Only the word index takes part in the compare.
   logic w_unused_ld_lsb;
   assign w_unused_ld_lsb = ^ld_addr[1:0];

`ifdef STB_FWD_EN
   logic [AW-3:0] w_ent_word [DEPTH];
   logic [DW-1:0] w_ent_data [DEPTH];
   logic [BE_W-1:0] w_ent_be [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ent_word[i] = r_mem[i].addr[AW-1:2];
         w_ent_data[i] = r_mem[i].data;
         w_ent_be[i]   = r_mem[i].be;
      end
   end

   stb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd_match (
      .i_valid    (r_valid),
      .i_rd_ptr   (r_rd_ptr),
      .i_ent_word (w_ent_word),
      .i_ent_data (w_ent_data),
      .i_ent_be   (w_ent_be),
      .i_ld_word  (ld_addr[AW-1:2]),
      .o_fwd_be   (ld_fwd_be),
      .o_fwd_data (ld_fwd_data)
   );

   assign ld_conflict = 1'b0;
`else
   logic w_word_hit;

   always_comb begin
      w_word_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_mem[i].addr[AW-1:2] == ld_addr[AW-1:2])) w_word_hit = 1'b1;
      end
   end

   assign ld_conflict = w_word_hit;
   assign ld_fwd_be   = '0;
   assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;

   logic            CLK = 1'b0;
   logic            Reset;
   logic            st_valid;
   logic            st_ready;
   logic [AW-1:0]   st_addr;
   logic [DW-1:0]   st_data;
   logic [BW-1:0]   st_be;
   logic [AW-1:0]   st_pc;
   logic            dm_wr;
   logic [AW-1:0]   dm_addr;
   logic [DW-1:0]   dm_wd;
   logic [BW-1:0]   dm_be;
   logic [AW-1:0]   dm_pc;
   logic            dm_busy;
   logic [AW-1:0]   ld_addr;
   logic            ld_conflict;
   logic [BW-1:0]   ld_fwd_be;
   logic [DW-1:0]   ld_fwd_data;
   logic            fence_req;
   logic            fence_done;
   logic            empty;
   dm_stb_pkg::stb_state_e dbg_state;

   dm_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_be       (st_be),
      .st_pc       (st_pc),
      .dm_wr       (dm_wr),
      .dm_addr     (dm_addr),
      .dm_wd       (dm_wd),
      .dm_be       (dm_be),
      .dm_pc       (dm_pc),
      .dm_busy     (dm_busy),
      .ld_addr     (ld_addr),
      .ld_conflict (ld_conflict),
      .ld_fwd_be   (ld_fwd_be),
      .ld_fwd_data (ld_fwd_data),
      .fence_req   (fence_req),
      .fence_done  (fence_done),
      .empty       (empty),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
      logic [AW-1:0] pc;
   } m_ent_t;

   m_ent_t mq[$];      // pending stores, oldest first
   bit     m_fencing;  // fence requested, buffer not yet empty
   bit     m_done;     // completion pulse visible this cycle

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic          e_rdy;
      logic          e_wr;
      logic          e_conf;
      logic [BW-1:0] e_fbe;
      logic [DW-1:0] e_fd;
      m_ent_t        h;
      e_rdy  = (mq.size() < DEPTH) && !m_fencing && !m_done;
      e_wr   = (mq.size() > 0) && !dm_busy;
      h      = '{default: '0};
      if (mq.size() > 0) h = mq[0];
      e_conf = 1'b0;
      e_fbe  = '0;
      e_fd   = '0;
      foreach (mq[i]) begin
         if (mq[i].addr[AW-1:2] == ld_addr[AW-1:2]) begin
`ifdef STB_FWD_EN
            for (int l = 0; l < BW; l++) begin
               if (mq[i].be[l]) begin
                  e_fbe[l]      = 1'b1;
                  e_fd[8*l +: 8] = mq[i].data[8*l +: 8];
               end
            end
`else
            e_conf = 1'b1;
`endif
         end
      end
      chk("model st_ready",    st_ready,    e_rdy);
      chk("model dm_wr",       dm_wr,       e_wr);
      chk("model dm_addr",     dm_addr,     h.addr);
      chk("model dm_wd",       dm_wd,       h.data);
      chk("model dm_be",       dm_be,       h.be);
      chk("model dm_pc",       dm_pc,       h.pc);
      chk("model empty",       empty,       mq.size() == 0);
      chk("model fence_done",  fence_done,  m_done);
      chk("model ld_conflict", ld_conflict, e_conf);
      chk("model ld_fwd_be",   ld_fwd_be,   e_fbe);
      chk("model ld_fwd_data", ld_fwd_data, e_fd);
   endtask

   task automatic model_update();
      bit     rdy;
      bit     pop;
      bit     start;
      m_ent_t e;
      if (Reset) begin
         mq.delete();
         m_fencing = 0;
         m_done    = 0;
      end else begin
         rdy   = (mq.size() < DEPTH) && !m_fencing && !m_done;
         pop   = (mq.size() > 0) && !dm_busy;
         start = fence_req && !m_fencing && !m_done;
         if (pop) void'(mq.pop_front());
         if (st_valid && rdy) begin
            e = '{addr: st_addr, data: st_data, be: st_be, pc: st_pc};
            mq.push_back(e);
         end
         if (m_done) m_done = 0;
         else if (m_fencing || start) begin
            if (mq.size() == 0) begin
               m_fencing = 0;
               m_done    = 1;
            end else begin
               m_fencing = 1;
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs are driven 1 time unit after posedge; outputs are compared at
   // negedge; the model advances on posedge with the same inputs.
   task automatic to_neg();
      @(negedge CLK);
      model_check();
   endtask

   task automatic to_pos();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic cycle();
      to_neg();
      to_pos();
   endtask

   task automatic idle_inputs();
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      st_be     = '0;
      st_pc     = '0;
      dm_busy   = 1'b0;
      fence_req = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be, input logic busy);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_be    = be;
      st_pc    = a + 32'h0040_0000;
      dm_busy  = busy;
      cycle();
      st_valid = 1'b0;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic          v;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          busy;
      logic          exp_rdy;
      logic          exp_wr;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd;
      logic          exp_empty;
   } vec_t;

   vec_t          tv[15];
   logic [AW-1:0] addr_tbl[4];

   initial begin
      // single store latency, then fill with back-pressure and drain
      tv[0]  = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1};
      tv[1]  = '{1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1};
      tv[2]  = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h010, 32'hDEADBEEF, 1'b0};
      tv[3]  = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1};
      tv[4]  = '{1'b1, 32'h100, 32'hA1,       1'b1, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1};
      tv[5]  = '{1'b1, 32'h104, 32'hA2,       1'b1, 1'b1, 1'b0, 32'h100, 32'hA1,       1'b0};
      tv[6]  = '{1'b1, 32'h108, 32'hA3,       1'b1, 1'b1, 1'b0, 32'h100, 32'hA1,       1'b0};
      tv[7]  = '{1'b1, 32'h10C, 32'hA4,       1'b1, 1'b1, 1'b0, 32'h100, 32'hA1,       1'b0};
      tv[8]  = '{1'b1, 32'h110, 32'hA5,       1'b1, 1'b0, 1'b0, 32'h100, 32'hA1,       1'b0};
      tv[9]  = '{1'b1, 32'h110, 32'hA5,       1'b0, 1'b0, 1'b1, 32'h100, 32'hA1,       1'b0};
      tv[10] = '{1'b1, 32'h110, 32'hA5,       1'b0, 1'b1, 1'b1, 32'h104, 32'hA2,       1'b0};
      tv[11] = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h108, 32'hA3,       1'b0};
      tv[12] = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h10C, 32'hA4,       1'b0};
      tv[13] = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h110, 32'hA5,       1'b0};
      tv[14] = '{1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1};
      addr_tbl[0] = 32'h20;
      addr_tbl[1] = 32'h24;
      addr_tbl[2] = 32'h40;
      addr_tbl[3] = 32'h80;

      idle_inputs();
      ld_addr = 32'hFFFF_FF00;
      m_fencing = 0;
      m_done    = 0;

      // initial reset (state unknown before it, so no checks this cycle)
      Reset = 1'b1;
      @(posedge CLK);
      model_update();
      #1;
      Reset = 1'b0;

      // reset state
      to_neg();
      chk("reset st_ready", st_ready, 1'b1);
      chk("reset empty", empty, 1'b1);
      chk("reset dm_wr", dm_wr, 1'b0);
      chk("reset fence_done", fence_done, 1'b0);
      chk("reset ld_conflict", ld_conflict, 1'b0);
      chk("reset ld_fwd_be", ld_fwd_be, '0);
      to_pos();

      // table-driven latency / full / drain-order vectors
      for (int i = 0; i < 15; i++) begin
         st_valid = tv[i].v;
         st_addr  = tv[i].addr;
         st_data  = tv[i].data;
         st_be    = 4'hF;
         st_pc    = tv[i].addr + 32'h0040_0000;
         dm_busy  = tv[i].busy;
         to_neg();
         chk($sformatf("tv%0d st_ready", i), st_ready, tv[i].exp_rdy);
         chk($sformatf("tv%0d dm_wr", i),    dm_wr,    tv[i].exp_wr);
         chk($sformatf("tv%0d dm_addr", i),  dm_addr,  tv[i].exp_addr);
         chk($sformatf("tv%0d dm_wd", i),    dm_wd,    tv[i].exp_wd);
         chk($sformatf("tv%0d empty", i),    empty,    tv[i].exp_empty);
         to_pos();
      end
      idle_inputs();

      // reset mid-drain: pending entries are discarded
      push(32'h60, 32'h6, 4'hF, 1'b1);
      push(32'h64, 32'h7, 4'hF, 1'b1);
      push(32'h68, 32'h8, 4'hF, 1'b1);
      dm_busy = 1'b1;
      Reset   = 1'b1;
      cycle();
      Reset   = 1'b0;
      dm_busy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         to_neg();
         chk("rst_mid empty", empty, 1'b1);
         chk("rst_mid dm_wr", dm_wr, 1'b0);
         chk("rst_mid st_ready", st_ready, 1'b1);
         to_pos();
      end

      // fence with two queued stores
      push(32'h40, 32'h1111, 4'hF, 1'b1);
      push(32'h44, 32'h2222, 4'hF, 1'b1);
      fence_req = 1'b1;
      dm_busy   = 1'b1;
      cycle();
      fence_req = 1'b0;
      st_valid  = 1'b1;
      st_addr   = 32'h48;
      st_data   = 32'h3333;
      st_be     = 4'hF;
      to_neg();
      chk("fence held st_ready", st_ready, 1'b0);
      chk("fence held done", fence_done, 1'b0);
      to_pos();
      dm_busy = 1'b0;
      to_neg();
      chk("fence p1 dm_wr", dm_wr, 1'b1);
      chk("fence p1 dm_addr", dm_addr, 32'h40);
      chk("fence p1 st_ready", st_ready, 1'b0);
      chk("fence p1 done", fence_done, 1'b0);
      to_pos();
      to_neg();
      chk("fence p2 dm_wr", dm_wr, 1'b1);
      chk("fence p2 dm_addr", dm_addr, 32'h44);
      chk("fence p2 done", fence_done, 1'b0);
      to_pos();
      st_valid = 1'b0;
      to_neg();
      chk("fence p3 done", fence_done, 1'b1);
      chk("fence p3 dm_wr", dm_wr, 1'b0);
      chk("fence p3 st_ready", st_ready, 1'b0);
      to_pos();
      to_neg();
      chk("fence p4 done", fence_done, 1'b0);
      chk("fence p4 st_ready", st_ready, 1'b1);
      to_pos();

      // fence while empty
      fence_req = 1'b1;
      cycle();
      fence_req = 1'b0;
      to_neg();
      chk("fence_empty done", fence_done, 1'b1);
      to_pos();
      to_neg();
      chk("fence_empty done after", fence_done, 1'b0);
      to_pos();

      // store together with fence_req: drained before the fence completes
      st_valid  = 1'b1;
      st_addr   = 32'h50;
      st_data   = 32'h5555;
      st_be     = 4'h3;
      fence_req = 1'b1;
      to_neg();
      chk("st+fence st_ready", st_ready, 1'b1);
      to_pos();
      st_valid  = 1'b0;
      fence_req = 1'b0;
      to_neg();
      chk("st+fence dm_wr", dm_wr, 1'b1);
      chk("st+fence dm_be", dm_be, 4'h3);
      chk("st+fence early done", fence_done, 1'b0);
      to_pos();
      to_neg();
      chk("st+fence done", fence_done, 1'b1);
      to_pos();
      cycle();

      // load hitting two stores to the same word
      push(32'h20, 32'h11223344, 4'hF, 1'b1);
      push(32'h20, 32'h000000AA, 4'h1, 1'b1);
      ld_addr = 32'h22;
      dm_busy = 1'b1;
      to_neg();
`ifdef STB_FWD_EN
      chk("fwd ld_fwd_be", ld_fwd_be, 4'hF);
      chk("fwd ld_fwd_data", ld_fwd_data, 32'h112233AA);
      chk("fwd ld_conflict", ld_conflict, 1'b0);
`else
      chk("nofwd ld_conflict", ld_conflict, 1'b1);
      chk("nofwd ld_fwd_be", ld_fwd_be, 4'h0);
      chk("nofwd ld_fwd_data", ld_fwd_data, 32'h0);
`endif
      to_pos();
      dm_busy = 1'b0;
      to_neg();
`ifndef STB_FWD_EN
      chk("nofwd conflict drain1", ld_conflict, 1'b1);
`endif
      to_pos();
      to_neg();
`ifndef STB_FWD_EN
      chk("nofwd conflict drain2", ld_conflict, 1'b1);
`endif
      to_pos();
      to_neg();
      chk("ld drained conflict", ld_conflict, 1'b0);
      chk("ld drained fwd_be", ld_fwd_be, 4'h0);
      to_pos();

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         st_valid  = ($urandom_range(0, 2) != 0);
         st_addr   = addr_tbl[$urandom_range(0, 3)];
         st_data   = $urandom;
         st_be     = 4'($urandom_range(0, 15));
         st_pc     = $urandom;
         dm_busy   = ($urandom_range(0, 2) == 0);
         fence_req = ($urandom_range(0, 19) == 0);
         ld_addr   = addr_tbl[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
         Reset     = ($urandom_range(0, 149) == 0);
         cycle();
      end
      Reset = 1'b0;
      idle_inputs();
      for (int k = 0; k < 8; k++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
